// File: rtl/rsa_pkg.sv
// Shared constants for the RSA exponentiator front end: register map,
// CTRL/STAT bit positions and the one-hot sequencer state encoding.
package rsa_pkg;

  // Register map (word addresses)
  localparam int unsigned ADDR_X_LO   = 0;
  localparam int unsigned ADDR_X_HI   = 1;
  localparam int unsigned ADDR_E_LO   = 2;
  localparam int unsigned ADDR_E_HI   = 3;
  localparam int unsigned ADDR_M_LO   = 4;
  localparam int unsigned ADDR_M_HI   = 5;
  localparam int unsigned ADDR_Z_LO   = 6;
  localparam int unsigned ADDR_Z_HI   = 7;
  localparam int unsigned ADDR_CTRL   = 8;
  localparam int unsigned ADDR_CYCLES = 9;

  // CTRL write bits
  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_CLEAR = 1;

  // STAT read bits
  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;
  localparam int unsigned STAT_ERR  = 2;

  // Sequencer states, one-hot
  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_LAUNCH  = 5'b00010,
    S_WAIT    = 5'b00100,
    S_CAPTURE = 5'b01000,
    S_COOL    = 5'b10000
  } state_t;

endpackage

// File: rtl/rsa_op_regs.sv
// Operand/result word register file for the RSA exponentiator front end.
// Operand words are writable only while the sequencer is idle; the result
// is loaded by the sequencer. Reads are registered (one cycle latency).
module rsa_op_regs
  import rsa_pkg::*;
#(
  parameter int BITS   = 64,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              busy,
  input  logic              z_load,
  input  logic [BITS-1:0]   z_in,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [WORD_W-1:0] stat_word,
  input  logic [WORD_W-1:0] cycles_word,
  output logic [WORD_W-1:0] rd_data,
  output logic [BITS-1:0]   x,
  output logic [BITS-1:0]   e,
  output logic [BITS-1:0]   m
);

  logic [BITS-1:0]   x_q, e_q, m_q, z_q;
  logic [WORD_W-1:0] rd_nxt;

  assign x = x_q;
  assign e = e_q;
  assign m = m_q;

  // Read mux: select the addressed word; unmapped addresses read zero
  always_comb begin
    rd_nxt = '0;
    case (rd_addr)
      ADDR_W'(ADDR_X_LO):   rd_nxt = x_q[WORD_W-1:0];
      ADDR_W'(ADDR_X_HI):   rd_nxt = x_q[BITS-1:WORD_W];
      ADDR_W'(ADDR_E_LO):   rd_nxt = e_q[WORD_W-1:0];
      ADDR_W'(ADDR_E_HI):   rd_nxt = e_q[BITS-1:WORD_W];
      ADDR_W'(ADDR_M_LO):   rd_nxt = m_q[WORD_W-1:0];
      ADDR_W'(ADDR_M_HI):   rd_nxt = m_q[BITS-1:WORD_W];
      ADDR_W'(ADDR_Z_LO):   rd_nxt = z_q[WORD_W-1:0];
      ADDR_W'(ADDR_Z_HI):   rd_nxt = z_q[BITS-1:WORD_W];
      ADDR_W'(ADDR_CTRL):   rd_nxt = stat_word;
      ADDR_W'(ADDR_CYCLES): rd_nxt = cycles_word;
      default:              rd_nxt = '0;
    endcase
  end

  // Operand writes (dropped while busy), result capture and registered readback
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= '0;
      e_q     <= '0;
      m_q     <= '0;
      z_q     <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en && !busy) begin
        case (wr_addr)
          ADDR_W'(ADDR_X_LO): x_q[WORD_W-1:0]    <= wr_data;
          ADDR_W'(ADDR_X_HI): x_q[BITS-1:WORD_W] <= wr_data;
          ADDR_W'(ADDR_E_LO): e_q[WORD_W-1:0]    <= wr_data;
          ADDR_W'(ADDR_E_HI): e_q[BITS-1:WORD_W] <= wr_data;
          ADDR_W'(ADDR_M_LO): m_q[WORD_W-1:0]    <= wr_data;
          ADDR_W'(ADDR_M_HI): m_q[BITS-1:WORD_W] <= wr_data;
          default: ;
        endcase
      end
      if (z_load) begin
        z_q <= z_in;
      end
      rd_data <= rd_nxt;
    end
  end

endmodule

// File: rtl/rsa_exp_sequencer.sv
// Host-side sequencer for the 64-bit Montgomery exponentiator. Collects
// X/E/M over a 32-bit word bus, holds the core's go high for the whole
// operation, captures Z on done, then keeps go low for a cool-down cycle
// so the core returns to its reset state before the next operation.
// Optional build macro: RSA_CYCLE_COUNT_EN adds a saturating count of
// WAIT_DONE cycles readable at address 9 (reads 0 when not defined).
module rsa_exp_sequencer
  import rsa_pkg::*;
#(
  parameter int BITS   = 64,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data,
  output logic              busy,
  output logic              irq,
  output logic [BITS-1:0]   exp_X,
  output logic [BITS-1:0]   exp_E,
  output logic [BITS-1:0]   exp_M,
  output logic              exp_go,
  input  logic              exp_done,
  input  logic [BITS-1:0]   exp_Z
);

  state_t state_q, state_nxt;
  logic   go_q, go_nxt;
  logic   done_q, done_nxt;
  logic   err_q, err_nxt;
  logic   z_load;
  logic   ctrl_wr, start, clear, m_ok;

  logic [WORD_W-1:0] stat_word;
  logic [WORD_W-1:0] cycles_word;

  assign ctrl_wr = wr_en && (wr_addr == ADDR_W'(ADDR_CTRL));
  assign start   = ctrl_wr && wr_data[CTRL_START];
  assign clear   = ctrl_wr && wr_data[CTRL_CLEAR];
  // Montgomery reduction needs an odd modulus greater than one
  assign m_ok    = exp_M[0] && (exp_M != BITS'(1));

  assign busy   = (state_q != S_IDLE);
  assign irq    = done_q;
  assign exp_go = go_q;

  assign stat_word = {{(WORD_W-3){1'b0}}, err_q, done_q, busy};

  rsa_op_regs #(
    .BITS   (BITS),
    .WORD_W (WORD_W),
    .ADDR_W (ADDR_W)
  ) u_regs (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .z_load      (z_load),
    .z_in        (exp_Z),
    .rd_addr     (rd_addr),
    .stat_word   (stat_word),
    .cycles_word (cycles_word),
    .rd_data     (rd_data),
    .x           (exp_X),
    .e           (exp_E),
    .m           (exp_M)
  );

  // Next-state, go and flag logic; a clear in the same write as a start applies first
  always_comb begin
    state_nxt = state_q;
    go_nxt    = go_q;
    done_nxt  = done_q;
    err_nxt   = err_q;
    z_load    = 1'b0;
    if (clear) begin
      done_nxt = 1'b0;
      err_nxt  = 1'b0;
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (m_ok) begin
            state_nxt = S_LAUNCH;
            go_nxt    = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      S_LAUNCH: begin
        go_nxt    = 1'b1;
        done_nxt  = 1'b0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (exp_done) begin
          z_load    = 1'b1;
          state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        go_nxt    = 1'b0;
        state_nxt = S_COOL;
      end
      S_COOL: begin
        done_nxt  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        go_nxt    = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and control flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      go_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      go_q    <= go_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
    end
  end

`ifdef RSA_CYCLE_COUNT_EN
  logic [31:0] cyc_q;

  // Saturating WAIT_DONE cycle counter, zeroed at launch, frozen after capture
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
    end else if (state_q == S_LAUNCH) begin
      cyc_q <= '0;
    end else if ((state_q == S_WAIT) && (cyc_q != 32'hFFFF_FFFF)) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign cycles_word = WORD_W'(cyc_q);
`else
  assign cycles_word = '0;
`endif

endmodule

// File: tb/tb_rsa_exp_sequencer.sv
// Self-checking bench for rsa_exp_sequencer with a behavioural exponentiator core.
module tb_rsa_exp_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        busy, irq, exp_go, exp_done;
  logic [63:0] exp_X, exp_E, exp_M, exp_Z;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rsa_exp_sequencer #(.BITS(64), .WORD_W(32), .ADDR_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy),
    .irq      (irq),
    .exp_X    (exp_X),
    .exp_E    (exp_E),
    .exp_M    (exp_M),
    .exp_go   (exp_go),
    .exp_done (exp_done),
    .exp_Z    (exp_Z)
  );

  // Reference: plain square-and-multiply modular exponentiation
  function automatic logic [63:0] ref_modexp(input logic [63:0] b, input logic [63:0] e,
                                             input logic [63:0] m);
    logic [127:0] r, bb, mm;
    mm = {64'd0, m};
    r  = 128'd1 % mm;
    bb = {64'd0, b} % mm;
    for (int i = 0; i < 64; i++) begin
      if (e[i]) r = (r * bb) % mm;
      bb = (bb * bb) % mm;
    end
    return r[63:0];
  endfunction

  // Behavioural core: done N cycles after go is seen high, cleared whenever go is low
  int          core_n = 20;
  int          core_cnt = 0;
  logic        core_done = 1'b0;
  logic [63:0] core_z = '0;

  always @(posedge clk) begin
    if (!exp_go) begin
      core_cnt  <= 0;
      core_done <= 1'b0;
    end else begin
      core_cnt <= core_cnt + 1;
      if (core_cnt + 1 >= core_n) begin
        core_done <= 1'b1;
        core_z    <= ref_modexp(exp_X, exp_E, exp_M);
      end
    end
  end

  assign exp_done = core_done;
  assign exp_Z    = core_done ? core_z : 64'hA5A5_5A5A_0F0F_F0F0;

  // Monitor: count go rising edges and the shortest low run between operations
  int   go_rises = 0;
  int   low_run = 0;
  int   min_gap = 1000;
  logic go_prev = 1'b0;
  bit   go_seen = 1'b0;

  always @(negedge clk) begin
    if (exp_go && !go_prev) begin
      go_rises++;
      if (go_seen && low_run < min_gap) min_gap = low_run;
      go_seen = 1'b1;
    end
    if (!exp_go) low_run++;
    else low_run = 0;
    go_prev = exp_go;
  end

  task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic read_reg(input logic [3:0] a, output logic [31:0] d);
    rd_addr = a;
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic read64(input logic [3:0] lo_a, output logic [63:0] d);
    logic [31:0] lo, hi;
    read_reg(lo_a, lo);
    read_reg(lo_a + 4'd1, hi);
    d = {hi, lo};
  endtask

  task automatic set_ops(input logic [63:0] x, input logic [63:0] e, input logic [63:0] m);
    write_reg(4'd0, x[31:0]); write_reg(4'd1, x[63:32]);
    write_reg(4'd2, e[31:0]); write_reg(4'd3, e[63:32]);
    write_reg(4'd4, m[31:0]); write_reg(4'd5, m[63:32]);
  endtask

  task automatic wait_idle(output bit ok);
    for (int i = 0; i < 500; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    ok = !busy;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    checks++;
    if (exp_go !== 1'b0 || busy !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: go=%b busy=%b irq=%b, required all 0", exp_go, busy, irq);
    end
    for (int a = 0; a < 16; a++) begin
      read_reg(4'(a), d);
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("FAIL reset_read addr=%0d: got %h, required 0", a, d);
      end
    end
  endtask

  task automatic test_basic();
    logic [63:0] z;
    logic [31:0] s;
    bit ok;
    int lat;
    core_n = 20;
    set_ops(64'd5, 64'd3, 64'd33);
    write_reg(4'd8, 32'd1);
    checks++;
    if (exp_go !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: go=%b busy=%b one cycle after start, required 1/1", exp_go, busy);
    end
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (exp_done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    lat = 0;
    while (!irq && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (!ok || lat != 3) begin
      errors++;
      $display("FAIL irq_latency: done_seen=%0d latency=%0d, required 1/3", ok, lat);
    end
    read64(4'd6, z);
    checks++;
    if (z !== 64'd26) begin
      errors++;
      $display("FAIL basic_z: got %0d, required 26", z);
    end
    read_reg(4'd8, s);
    checks++;
    if (s !== 32'b010) begin
      errors++;
      $display("FAIL basic_stat: got %b, required 010", s);
    end
  endtask

  task automatic test_bad_modulus();
    logic [31:0] s;
    int r0;
    bit bad;
    write_reg(4'd8, 32'd2);
    set_ops(64'd5, 64'd3, 64'd34);
    r0 = go_rises;
    write_reg(4'd8, 32'd1);
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (exp_go !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad || go_rises != r0) begin
      errors++;
      $display("FAIL even_m_no_launch: go/busy rose, rises=%0d, required %0d", go_rises, r0);
    end
    read_reg(4'd8, s);
    checks++;
    if (s !== 32'b100) begin
      errors++;
      $display("FAIL even_m_stat: got %b, required 100", s);
    end
    write_reg(4'd8, 32'd2);
    read_reg(4'd8, s);
    checks++;
    if (s !== 32'b000) begin
      errors++;
      $display("FAIL clear_stat: got %b, required 000", s);
    end
    write_reg(4'd4, 32'd1);
    write_reg(4'd8, 32'd1);
    read_reg(4'd8, s);
    checks++;
    if (s !== 32'b100 || go_rises != r0) begin
      errors++;
      $display("FAIL m_one_err: stat=%b rises=%0d, required 100 and %0d", s, go_rises, r0);
    end
    write_reg(4'd8, 32'd2);
  endtask

  task automatic test_busy_protect();
    logic [31:0] d;
    logic [63:0] z;
    int r0;
    bit ok, low2;
    core_n = 30;
    set_ops(64'd5, 64'd7, 64'd33);
    r0 = go_rises;
    write_reg(4'd8, 32'd1);
    repeat (3) @(negedge clk);
    write_reg(4'd0, 32'd7);
    write_reg(4'd8, 32'd1);
    wait_idle(ok);
    low2 = (exp_go === 1'b0);
    @(negedge clk);
    low2 = low2 && (exp_go === 1'b0);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL busy_timeout: still busy, required idle");
    end
    read_reg(4'd0, d);
    checks++;
    if (d !== 32'd5) begin
      errors++;
      $display("FAIL busy_write_drop: X_LO=%0d, required 5", d);
    end
    checks++;
    if (go_rises - r0 != 1) begin
      errors++;
      $display("FAIL single_capture: go rises=%0d, required 1", go_rises - r0);
    end
    checks++;
    if (!low2) begin
      errors++;
      $display("FAIL cooldown_low: go not low 2 cycles, required low");
    end
    read64(4'd6, z);
    checks++;
    if (z !== ref_modexp(64'd5, 64'd7, 64'd33)) begin
      errors++;
      $display("FAIL busy_z: got %0d, required %0d", z, ref_modexp(64'd5, 64'd7, 64'd33));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [63:0] z;
    bit ok;
    core_n = 30;
    set_ops(64'd9, 64'd5, 64'd33);
    write_reg(4'd8, 32'd1);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (exp_go !== 1'b0 || busy !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: go=%b busy=%b irq=%b, required 0/0/0", exp_go, busy, irq);
    end
    rst = 1'b0;
    for (int a = 0; a < 10; a++) begin
      read_reg(4'(a), d);
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("FAIL mid_reset_read addr=%0d: got %h, required 0", a, d);
      end
    end
    core_n = 12;
    set_ops(64'd2, 64'd10, 64'd1000003);
    write_reg(4'd8, 32'd1);
    wait_idle(ok);
    read64(4'd6, z);
    checks++;
    if (!ok || z !== 64'd1024) begin
      errors++;
      $display("FAIL after_reset_z: ok=%0d z=%0d, required 1 and 1024", ok, z);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] z, m;
    logic [31:0] s;
    bit ok;
    int r0;
    m = 64'hFFFF_FFFF_FFFF_FFC5;
    core_n = 8;
    set_ops(64'd2, m - 64'd1, m);
    r0 = go_rises;
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin
        read_reg(4'd8, s);
        checks++;
        if (s[1] !== 1'b1) begin
          errors++;
          $display("FAIL b2b_done_before: done=%b, required 1", s[1]);
        end
      end
      write_reg(4'd8, 32'd1);
      wait_idle(ok);
      read64(4'd6, z);
      checks++;
      if (!ok || z !== 64'd1 || irq !== 1'b1) begin
        errors++;
        $display("FAIL b2b_op%0d: ok=%0d z=%h irq=%b, required 1/1/1", k, ok, z, irq);
      end
    end
    checks++;
    if (go_rises - r0 != 2 || min_gap < 2) begin
      errors++;
      $display("FAIL b2b_go: rises=%0d min_gap=%0d, required 2 and >=2", go_rises - r0, min_gap);
    end
  endtask

  task automatic test_cycles();
    logic [31:0] d, want;
    bit ok;
    core_n = 37;
    set_ops(64'd3, 64'd11, 64'd101);
    write_reg(4'd8, 32'd1);
    wait_idle(ok);
    read_reg(4'd9, d);
`ifdef RSA_CYCLE_COUNT_EN
    want = 32'd37;
`else
    want = 32'd0;
`endif
    checks++;
    if (!ok || d !== want) begin
      errors++;
      $display("FAIL cycles: ok=%0d got %0d, required %0d", ok, d, want);
    end
  endtask

  task automatic test_random();
    logic [63:0] x, e, m, z, want;
    logic [31:0] d;
    bit ok;
    for (int k = 0; k < 6; k++) begin
      x = {$urandom, $urandom};
      e = {$urandom, $urandom};
      m = {$urandom, $urandom} | 64'd1;
      if (m == 64'd1) m = 64'd3;
      core_n = $urandom_range(1, 40);
      set_ops(x, e, m);
      write_reg(4'd8, ($urandom_range(0, 1) != 0) ? 32'd3 : 32'd1);
      wait_idle(ok);
      read64(4'd6, z);
      want = ref_modexp(x, e, m);
      checks++;
      if (!ok || z !== want) begin
        errors++;
        $display("FAIL random_z%0d: ok=%0d got %h, required %h", k, ok, z, want);
      end
`ifdef RSA_CYCLE_COUNT_EN
      read_reg(4'd9, d);
      checks++;
      if (d !== 32'(core_n)) begin
        errors++;
        $display("FAIL random_cycles%0d: got %0d, required %0d", k, d, core_n);
      end
`else
      read_reg(4'd9, d);
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("FAIL random_cycles%0d: got %0d, required 0", k, d);
      end
`endif
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_bad_modulus();
    test_busy_protect();
    test_reset_mid();
    test_back_to_back();
    test_cycles();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
